store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Store-side counterpart of the immediate/load width extension path: narrows a 32-bit register value to a byte, half or word and places it on the correct byte lanes of the Avalon-style data-memory bus.
- Sits between the CPU datapath (SB/SH/SW execution) and the data-memory master port.
- Owns the write handshake: holds the request stable through waitrequest and signals completion so the pipeline can release its stall.

Parameters:
- ADDR_W, 32, byte-address width.
- WAIT_LIMIT, 0, maximum cycles a write may sit in waitrequest before it is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request from the datapath.
- req_ready  out  1  high when the unit can accept a request.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_addr  in  ADDR_W  byte address of the store.
- req_data  in  32  source register value; the low bits are used for byte/half.
- done  out  1  one-cycle pulse when the store completes.
- err  out  1  one-cycle pulse on misalignment, illegal size or timeout.
- address  out  ADDR_W  word-aligned bus address ({req_addr[ADDR_W-1:2],2'b00}).
- write  out  1  bus write strobe.
- writedata  out  32  lane-replicated store data.
- byteenable  out  4  active byte lanes.
- waitrequest  in  1  slave stall.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; write=0, done=0, err=0, address=0, writedata=0, byteenable=0, wait counter=0. Reset asserted mid-write drops write immediately; the store is lost and no done/err is produced.
- States: IDLE, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 with a legal, aligned request: register address, writedata and byteenable; go to WRITE.
  - On an illegal or misaligned request: no bus access, err=1 next cycle, stay in IDLE.
- WRITE:
  - req_ready=0. write=1; address, writedata and byteenable are held constant.
  - On a cycle with waitrequest=0: go to RESP, deassert write.
  - Otherwise increment the wait counter.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT while waitrequest=1: drop write, pulse err, return to IDLE, no done.
- RESP: done=1 for exactly one cycle, counter cleared, return to IDLE; req_ready=0 during this cycle.
- Latency: with waitrequest=0, request accepted at cycle N, write high at N+1, done at N+2. Throughput is one store per 3 cycles at best.
- Lane mapping (little-endian, k=req_addr[1:0]):
  - Byte: writedata={4{req_data[7:0]}}, byteenable=4'b0001<<k; always aligned.
  - Half: writedata={2{req_data[15:0]}}, byteenable=req_addr[1]?4'b1100:4'b0011; misaligned if req_addr[0]=1.
  - Word: writedata=req_data, byteenable=4'b1111; misaligned if k≠0.
  - Size 11: illegal, treated like a misaligned request.
- Unused lanes carry replicated data; the slave must honour byteenable.
- In IDLE, write=0 and byteenable retains its last value (don't-care to the slave).
- req_valid arriving while req_ready=0 is ignored; the datapath must hold it.
- err and done are never asserted in the same cycle.

Decomposition:
- Shared package store_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL);
  - state enum (ST_IDLE, ST_WRITE, ST_RESP);
  - BE_WORD, BE_HALF_LO, BE_HALF_HI constants.
- One combinational sub-module, store_lane_align: inputs size, addr[1:0] and data; outputs writedata, byteenable and misaligned.
- The top level holds the FSM, output registers and wait counter.

Test Plan:
- SB, addr=0x1003, data=0xAABBCC5A, waitrequest=0 → address=0x1000, byteenable=4'b1000, writedata=0x5A5A5A5A, write for 1 cycle, done at N+2.
- SH, addr=0x2002, data=0x12348765, waitrequest high for 3 cycles → byteenable=4'b1100, writedata=0x87658765 held stable 4 cycles, done once after release.
- SW, addr=0x3001 → no write, err pulse at N+1, req_ready stays 1; then SW at 0x3004 with data 0xDEADBEEF → byteenable=4'b1111, done.
- WAIT_LIMIT=4, waitrequest stuck high → write high 4 cycles then low, err=1 once, done never, next request accepted.
- rst_n pulled low during WRITE with waitrequest=1 → write=0 asynchronously, no done/err; after release, SB at 0x0 completes normally.
- req_size=2'b11 at addr 0x0 → err pulse, no bus access.

Source files
------------

// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_pkg
// Description : Shared types and byte-enable constants for the store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package store_pkg;

    // Store access width as encoded by the datapath.
    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    // Write handshake states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : store_lane_align
// Description : Narrows a register value to byte/half/word, replicates it
//               across the 32-bit bus and derives byte enables and alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module store_lane_align
    import store_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    output logic        misaligned
);

    // Little-endian lane placement; unused lanes carry replicated data.
    always_comb begin
        writedata  = data;
        byteenable = BE_WORD;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                writedata  = {4{data[7:0]}};
                byteenable = BE_BYTE0 << addr;
            end
            SZ_HALF: begin
                writedata  = {2{data[15:0]}};
                byteenable = addr[1] ? BE_HALF_HI : BE_HALF_LO;
                misaligned = addr[0];
            end
            SZ_WORD: begin
                misaligned = (addr != 2'b00);
            end
            default: begin
                // Illegal size is reported through the misalignment path.
                misaligned = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_unit
// Description : Store path to an Avalon-style data-memory master. Registers
//               lane-aligned data, holds it through waitrequest, and pulses
//               done on completion or err on misalignment/illegal/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module store_unit
    import store_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WAIT_LIMIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic              waitrequest
);

    // Counter wide enough to hold WAIT_LIMIT-1; a single bit when disabled.
    localparam int              CNT_W    = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W:0]  LIMIT_M1 = (CNT_W + 1)'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [31:0]         writedata_q, writedata_d;
    logic [3:0]          byteenable_q, byteenable_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic [31:0]         lane_writedata;
    logic [3:0]          lane_byteenable;
    logic                lane_misaligned;
    logic                timeout_hit;

    store_lane_align u_lane_align (
        .size       (size_e'(req_size)),
        .addr       (req_addr[1:0]),
        .data       (req_data),
        .writedata  (lane_writedata),
        .byteenable (lane_byteenable),
        .misaligned (lane_misaligned)
    );

    // Timeout fires on the stalled cycle that brings the count to WAIT_LIMIT.
    always_comb begin
        timeout_hit = (WAIT_LIMIT != 0) && ({1'b0, wait_cnt_q} == LIMIT_M1);
    end

    // Next-state and registered-output logic for the write handshake.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                write_d    = 1'b0;
                wait_cnt_d = '0;
                if (req_valid) begin
                    if (lane_misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        address_d    = {req_addr[ADDR_W-1:2], 2'b00};
                        writedata_d  = lane_writedata;
                        byteenable_d = lane_byteenable;
                        write_d      = 1'b1;
                        state_d      = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (!waitrequest) begin
                    write_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    write_d    = 1'b0;
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                wait_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                write_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops an in-flight write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            done_q       <= done_d;
            err_q        <= err_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign address    = address_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_unit
// Description : Self-checking bench for store_unit with a completion
//               scoreboard and per-scenario timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_store_unit;

    localparam int ADDR_W     = 32;
    localparam int WAIT_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        done, err, write;
    logic [31:0] address, writedata;
    logic [3:0]  byteenable;
    logic        waitrequest = 1'b0;

    typedef struct {
        logic        is_err;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_data = '0;
    logic [3:0]  cap_be   = '0;

    store_unit #(.ADDR_W(ADDR_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .done        (done),
        .err         (err),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest)
    );

    always #5 clk = ~clk;

    // Reference model: lane l is enabled when it falls in the same
    // naturally-aligned chunk as the address; data repeats every nbytes.
    function automatic exp_t model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   nb;
        int   k;
        k = int'(a[1:0]);
        case (sz)
            2'b00:   nb = 1;
            2'b01:   nb = 2;
            2'b10:   nb = 4;
            default: nb = 0;
        endcase
        e.addr = {a[31:2], 2'b00};
        e.data = '0;
        e.be   = '0;
        e.is_err = (nb == 0) || ((k % nb) != 0);
        if (nb != 0) begin
            for (int l = 0; l < 4; l++) begin
                e.data[8*l +: 8] = d[8*(l % nb) +: 8];
                e.be[l]          = ((l / nb) == (k / nb));
            end
        end
        return e;
    endfunction

    // Scoreboard: capture bus during write, pop and compare on done/err.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (write) begin
                cap_addr = address;
                cap_data = writedata;
                cap_be   = byteenable;
            end
            if (done || err) begin
                n_tests++;
                if (done && err) begin
                    n_fail++;
                    $display("FAIL sb_exclusive done=%b err=%b required not both", done, err);
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected done=%b err=%b with no pending store", done, err);
                end else begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (err !== e.is_err) begin
                        n_fail++;
                        $display("FAIL sb_kind err=%b required=%b", err, e.is_err);
                    end else if (done) begin
                        n_tests++;
                        if (cap_addr !== e.addr || cap_data !== e.data || cap_be !== e.be) begin
                            n_fail++;
                            $display("FAIL sb_bus addr=%h data=%h be=%b required addr=%h data=%h be=%b",
                                     cap_addr, cap_data, cap_be, e.addr, e.data, e.be);
                        end
                    end
                end
            end
        end
    end

    // Present one request for one accepted cycle; kind 0=untracked, 1=model, 2=timeout err.
    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input int kind);
        exp_t e;
        int   waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready req_ready=%b required=1 within 20 cycles", req_ready);
        end
        req_valid = 1'b1;
        req_size  = sz;
        req_addr  = a;
        req_data  = d;
        e = model(sz, a, d);
        if (kind == 2) e.is_err = 1'b1;
        if (kind != 0) exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_tests++;
        if ({write, done, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes write/done/err=%b required=000", {write, done, err});
        end
        n_tests++;
        if (address !== 32'h0 || writedata !== 32'h0 || byteenable !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_bus addr=%h data=%h be=%b required zeros", address, writedata, byteenable);
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready req_ready=%b required=1", req_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sb();
        waitrequest = 1'b0;
        issue(2'b00, 32'h0000_1003, 32'hAABB_CC5A, 1);
        n_tests++;
        if (write !== 1'b1 || address !== 32'h1000 || byteenable !== 4'b1000 || writedata !== 32'h5A5A_5A5A) begin
            n_fail++;
            $display("FAIL sb_bus write=%b addr=%h be=%b data=%h required 1/1000/1000/5a5a5a5a",
                     write, address, byteenable, writedata);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b1 || write !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_done done=%b write=%b required done=1 write=0", done, write);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_after done=%b ready=%b required 0/1", done, req_ready);
        end
    endtask

    task automatic test_sh_wait();
        int dones = 0;
        waitrequest = 1'b1;
        issue(2'b01, 32'h0000_2002, 32'h1234_8765, 1);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (write !== 1'b1 || byteenable !== 4'b1100 || writedata !== 32'h8765_8765 || address !== 32'h2000) begin
                n_fail++;
                $display("FAIL sh_hold cyc=%0d write=%b be=%b data=%h addr=%h required 1/1100/87658765/2000",
                         i, write, byteenable, writedata, address);
            end
            if (i == 3) waitrequest = 1'b0;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            if (i == 0) begin
                n_tests++;
                if (done !== 1'b1 || write !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sh_done done=%b write=%b required 1/0", done, write);
                end
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL sh_done_count got=%0d required=1", dones);
        end
    endtask

    task automatic test_misaligned();
        waitrequest = 1'b0;
        issue(2'b10, 32'h0000_3001, 32'h0102_0304, 1);
        n_tests++;
        if (err !== 1'b1 || write !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_misal err=%b write=%b ready=%b required 1/0/1", err, write, req_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_misal_pulse err=%b required=0", err);
        end
        issue(2'b10, 32'h0000_3004, 32'hDEAD_BEEF, 1);
        n_tests++;
        if (byteenable !== 4'b1111 || writedata !== 32'hDEAD_BEEF || address !== 32'h3004) begin
            n_fail++;
            $display("FAIL sw_bus be=%b data=%h addr=%h required 1111/deadbeef/3004", byteenable, writedata, address);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_done done=%b required=1", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        waitrequest = 1'b1;
        issue(2'b00, 32'h0000_0010, 32'h0000_0005, 2);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (write !== 1'b1 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL to_write cyc=%0d write=%b err=%b required 1/0", i, write, err);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (write !== 1'b0 || err !== 1'b1 || done !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL to_abort write=%b err=%b done=%b ready=%b required 0/1/0/1", write, err, done, req_ready);
        end
        waitrequest = 1'b0;
        issue(2'b01, 32'h0000_0000, 32'hCAFE_0102, 1);
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL to_next done=%b required=1", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        waitrequest = 1'b1;
        issue(2'b00, 32'h0000_0040, 32'h0000_0077, 0);
        n_tests++;
        if (write !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre write=%b required=1", write);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (write !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async write=%b done=%b err=%b required 000", write, done, err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        waitrequest = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_silent done=%b err=%b required 0/0", done, err);
        end
        issue(2'b00, 32'h0000_0000, 32'h0000_0011, 1);
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_recover done=%b required=1", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        waitrequest = 1'b0;
        issue(2'b11, 32'h0000_0000, 32'h1111_2222, 1);
        n_tests++;
        if (err !== 1'b1 || write !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal err=%b write=%b required 1/0", err, write);
        end
        @(posedge clk); #1;
    endtask

    // Back-to-back sweep of lane positions; results are checked by the scoreboard.
    task automatic test_lanes();
        logic [1:0]  sz_t [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        logic [31:0] ad_t [8] = '{32'h100, 32'h101, 32'h102, 32'h200, 32'h202, 32'h203, 32'h300, 32'h302};
        waitrequest = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(sz_t[i], ad_t[i], $urandom, 1);
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sb();
        test_sh_wait();
        test_misaligned();
        test_timeout();
        test_reset_mid_write();
        test_illegal();
        test_lanes();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain pending=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
